// File: rtl/ttc_pkg.sv
// Shared types and constants for the truth_table_checker block.
package ttc_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      CHECK   = 2'd2,
      DONE    = 2'd3
   } ttc_state_e;

   // x^8 + x^6 + x^5 + x^4 + 1, with the x^8 term implied by the shift-out bit
   localparam logic [7:0] MISR_POLY        = 8'h71;
   localparam logic [7:0] MISR_SEED        = 8'hFF;
   localparam logic [7:0] TTC_EXPECTED_DEF = 8'hE8;

endpackage

// File: rtl/truth_table_checker_if.sv
// Sample stream from the stimulus side into the checker (valid/ready).
interface truth_table_checker_if #(
   parameter int N_IN = 3
);
   logic            s_valid;
   logic            s_ready;
   logic [N_IN-1:0] s_vec;
   logic            s_out;

   modport master (output s_valid, s_vec, s_out, input s_ready);
   modport slave  (input s_valid, s_vec, s_out, output s_ready);
endinterface

// File: rtl/ttc_misr.sv
// 8-bit multiple-input signature register with synchronous clear and enable.
module ttc_misr
   import ttc_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clr,
   input  logic       en,
   input  logic [7:0] din,
   output logic [7:0] sig
);

   logic [7:0] sig_q;
   logic [7:0] sig_d;

   always_comb begin
      sig_d = sig_q;
      if (clr) begin
         sig_d = MISR_SEED;
      end else if (en) begin
         sig_d = {sig_q[6:0], 1'b0} ^ (sig_q[7] ? MISR_POLY : 8'h00) ^ din;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sig_q <= MISR_SEED;
      end else begin
         sig_q <= sig_d;
      end
   end

   assign sig = sig_q;

endmodule

// File: rtl/truth_table_checker.sv
// Captures the truth table of a small combinational block from a sample stream
// and checks it against EXPECTED. Define TTC_SIGNATURE_EN to add the sig MISR port.
//
// state   | meaning
// IDLE    | after reset, waiting for start
// CAPTURE | accepting samples until every vector has been seen
// CHECK   | one cycle: compare captured table with EXPECTED
// DONE    | result held until next start
module truth_table_checker
   import ttc_pkg::*;
#(
   parameter int                    N_IN     = 3,
   parameter logic [(2**N_IN)-1:0]  EXPECTED = TTC_EXPECTED_DEF
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   truth_table_checker_if.slave    s_if,
   output logic                    busy,
   output logic                    done,
   output logic                    pass,
   output logic                    conflict,
   output logic [(2**N_IN)-1:0]    tt_table,
   output logic [(2**N_IN)-1:0]    seen
`ifdef TTC_SIGNATURE_EN
   ,
   output logic [7:0]              sig
`endif
);

   localparam int N_VEC = 2**N_IN;

   ttc_state_e       state_q, state_d;
   logic [N_VEC-1:0] tbl_q, tbl_d;
   logic [N_VEC-1:0] seen_q, seen_d;
   logic             pass_q, pass_d;
   logic             conflict_q, conflict_d;
   logic             accept;

   assign s_if.s_ready = (state_q == CAPTURE);
   assign accept       = s_if.s_valid && (state_q == CAPTURE);

   always_comb begin
      state_d    = state_q;
      tbl_d      = tbl_q;
      seen_d     = seen_q;
      pass_d     = pass_q;
      conflict_d = conflict_q;
      // start outranks everything, including a sample accepted in the same cycle
      if (start) begin
         state_d    = CAPTURE;
         tbl_d      = '0;
         seen_d     = '0;
         pass_d     = 1'b0;
         conflict_d = 1'b0;
      end else begin
         case (state_q)
            CAPTURE: begin
               if (accept) begin
                  if (!seen_q[s_if.s_vec]) begin
                     tbl_d[s_if.s_vec]  = s_if.s_out;
                     seen_d[s_if.s_vec] = 1'b1;
                  end else if (s_if.s_out != tbl_q[s_if.s_vec]) begin
                     conflict_d = 1'b1;
                  end
                  if (&seen_d) begin
                     state_d = CHECK;
                  end
               end
            end
            CHECK: begin
               pass_d  = (tbl_q == EXPECTED) && !conflict_q;
               state_d = DONE;
            end
            IDLE, DONE: begin
               state_d = state_q;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         tbl_q      <= '0;
         seen_q     <= '0;
         pass_q     <= 1'b0;
         conflict_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         tbl_q      <= tbl_d;
         seen_q     <= seen_d;
         pass_q     <= pass_d;
         conflict_q <= conflict_d;
      end
   end

   assign busy     = (state_q == CAPTURE);
   assign done     = (state_q == DONE);
   assign pass     = pass_q;
   assign conflict = conflict_q;
   assign tt_table = tbl_q;
   assign seen     = seen_q;

`ifdef TTC_SIGNATURE_EN
   logic [7:0] misr_din;
   assign misr_din = 8'({s_if.s_vec, s_if.s_out});

   ttc_misr u_misr (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (start),
      .en    (accept && !start),
      .din   (misr_din),
      .sig   (sig)
   );
`endif

endmodule

// File: tb/tb_truth_table_checker.sv
// Bench for truth_table_checker: directed scenarios plus randomized sample
// streams, checked every cycle against a table/array model of the checker.
module tb_truth_table_checker;

   localparam int         N_IN = 3;
   localparam logic [7:0] EXP  = 8'hE8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       busy, done, pass, conflict;
   logic [7:0] tt_table, seen;
`ifdef TTC_SIGNATURE_EN
   logic [7:0] sig;
   logic [7:0] sig_a;
`endif

   int vectors = 0;
   int miscompares = 0;

   // model: obs[k] is -1 while unseen, else the first output observed for vector k
   int m_phase;   // 0 idle, 1 capture, 2 check, 3 done
   int obs [8];
   bit m_conflict;
   bit m_pass;

   truth_table_checker_if #(.N_IN(N_IN)) bus ();

   truth_table_checker #(.N_IN(N_IN), .EXPECTED(EXP)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .s_if     (bus),
      .busy     (busy),
      .done     (done),
      .pass     (pass),
      .conflict (conflict),
      .tt_table (tt_table),
      .seen     (seen)
`ifdef TTC_SIGNATURE_EN
      ,
      .sig      (sig)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] m_tbl();
      logic [7:0] r = 8'h00;
      for (int k = 0; k < 8; k++) if (obs[k] == 1) r[k] = 1'b1;
      return r;
   endfunction

   function automatic logic [7:0] m_seen();
      logic [7:0] r = 8'h00;
      for (int k = 0; k < 8; k++) if (obs[k] >= 0) r[k] = 1'b1;
      return r;
   endfunction

   task automatic model_clear();
      for (int k = 0; k < 8; k++) obs[k] = -1;
      m_conflict = 1'b0;
      m_pass     = 1'b0;
   endtask

   // called right after each rising edge with the inputs that edge sampled
   task automatic model_step();
      int v;
      if (start) begin
         model_clear();
         m_phase = 1;
      end else if (m_phase == 1) begin
         if (bus.s_valid) begin
            v = int'(bus.s_vec);
            if (obs[v] < 0) obs[v] = int'(bus.s_out);
            else if (obs[v] != int'(bus.s_out)) m_conflict = 1'b1;
            if (m_seen() == 8'hFF) m_phase = 2;
         end
      end else if (m_phase == 2) begin
         m_pass  = (m_tbl() == EXP) && !m_conflict;
         m_phase = 3;
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         chk("s_ready", {7'b0, bus.s_ready}, {7'b0, m_phase == 1});
         if (m_phase != 2) chk("busy", {7'b0, busy}, {7'b0, m_phase == 1});
         chk("done", {7'b0, done}, {7'b0, m_phase == 3});
         chk("pass", {7'b0, pass}, {7'b0, m_pass});
         chk("conflict", {7'b0, conflict}, {7'b0, m_conflict});
         chk("table", tt_table, m_tbl());
         chk("seen", seen, m_seen());
      end
   end

   task automatic cyc(input bit st, input bit v, input int vec, input bit o);
      start       = st;
      bus.s_valid = v;
      bus.s_vec   = 3'(vec);
      bus.s_out   = o;
      @(posedge clk);
      model_step();
      @(negedge clk);
      start       = 1'b0;
      bus.s_valid = 1'b0;
   endtask

   // one sample per vector; rev sends 7..0, gaps idles s_valid between samples,
   // swap exchanges the first two samples of the forward order
   task automatic send_all(input logic [7:0] f, input bit rev, input bit gaps, input bit swap);
      for (int i = 0; i < 8; i++) begin
         int k;
         k = rev ? 7 - i : i;
         if (swap && i < 2) k = 1 - i;
         if (gaps) begin
            cyc(1'b0, 1'b0, 0, 1'b0);
            chk("ready_in_gap", {7'b0, bus.s_ready}, 8'h01);
         end
         cyc(1'b0, 1'b1, k, f[k]);
      end
   endtask

   task automatic check_final(input string tag, input bit p, input bit c, input logic [7:0] t);
      chk({tag, "_done"}, {7'b0, done}, 8'h01);
      chk({tag, "_pass"}, {7'b0, pass}, {7'b0, p});
      chk({tag, "_conflict"}, {7'b0, conflict}, {7'b0, c});
      chk({tag, "_table"}, tt_table, t);
      chk({tag, "_seen"}, seen, 8'hFF);
   endtask

   initial begin
      logic [7:0] maj;
      maj = EXP;
      bus.s_valid = 1'b0;
      bus.s_vec   = '0;
      bus.s_out   = 1'b0;
      m_phase = 0;
      model_clear();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      cyc(1'b0, 1'b1, 5, 1'b1);
      chk("idle_ignores_valid", seen, 8'h00);
`ifdef TTC_SIGNATURE_EN
      chk("sig_reset", sig, 8'hFF);
`endif

      // majority in order: done exactly two cycles after the last sample
      cyc(1'b1, 1'b0, 0, 1'b0);
      chk("ready_after_start", {7'b0, bus.s_ready}, 8'h01);
      send_all(maj, 1'b0, 1'b0, 1'b0);
      chk("done_at_check", {7'b0, done}, 8'h00);
      cyc(1'b0, 1'b0, 0, 1'b0);
      check_final("maj", 1'b1, 1'b0, 8'hE8);
`ifdef TTC_SIGNATURE_EN
      sig_a = sig;
`endif
      repeat (2) cyc(1'b0, 1'b1, 3, 1'b0);
      chk("done_ignores_valid", tt_table, 8'hE8);

      // reverse order with s_valid gaps
      cyc(1'b1, 1'b0, 0, 1'b0);
      send_all(maj, 1'b1, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 0, 1'b0);
      check_final("rev", 1'b1, 1'b0, 8'hE8);

      // conflicting observations of vector 3
      cyc(1'b1, 1'b0, 0, 1'b0);
      cyc(1'b0, 1'b1, 3, 1'b1);
      cyc(1'b0, 1'b1, 0, 1'b0);
      chk("conflict_before", {7'b0, conflict}, 8'h00);
      cyc(1'b0, 1'b1, 3, 1'b0);
      chk("conflict_after", {7'b0, conflict}, 8'h01);
      send_all(maj, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 0, 1'b0);
      check_final("conf", 1'b0, 1'b1, 8'hE8);

      // wrong DUT: constant zero
      cyc(1'b1, 1'b0, 0, 1'b0);
      send_all(8'h00, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 0, 1'b0);
      check_final("zero", 1'b0, 1'b0, 8'h00);

      // asynchronous reset mid-capture
      cyc(1'b1, 1'b0, 0, 1'b0);
      for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, i, maj[i]);
      #2 rst_n = 1'b0;
      m_phase = 0;
      model_clear();
      #1;
      chk("rst_ready", {7'b0, bus.s_ready}, 8'h00);
      chk("rst_busy", {7'b0, busy}, 8'h00);
      chk("rst_done", {7'b0, done}, 8'h00);
      chk("rst_pass", {7'b0, pass}, 8'h00);
      chk("rst_conflict", {7'b0, conflict}, 8'h00);
      chk("rst_table", tt_table, 8'h00);
      chk("rst_seen", seen, 8'h00);
`ifdef TTC_SIGNATURE_EN
      chk("rst_sig", sig, 8'hFF);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 4; i < 7; i++) cyc(1'b0, 1'b1, i, maj[i]);
      chk("post_rst_ignored", seen, 8'h00);
      cyc(1'b1, 1'b0, 0, 1'b0);
      send_all(maj, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 0, 1'b0);
      check_final("rerun", 1'b1, 1'b0, 8'hE8);

      // restart after 5 samples; the sample coinciding with start is dropped
      cyc(1'b1, 1'b0, 0, 1'b0);
      for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, i, maj[i]);
      cyc(1'b1, 1'b1, 6, 1'b1);
      chk("restart_seen", seen, 8'h00);
`ifdef TTC_SIGNATURE_EN
      chk("restart_sig", sig, 8'hFF);
`endif
      send_all(maj, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 0, 1'b0);
      check_final("restart", 1'b1, 1'b0, 8'hE8);
`ifdef TTC_SIGNATURE_EN
      chk("sig_repeatable", sig, sig_a);
      cyc(1'b1, 1'b0, 0, 1'b0);
      send_all(maj, 1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 0, 1'b0);
      chk("sig_order_sensitive", {7'b0, sig != sig_a}, 8'h01);
`endif

      // randomized streams: gaps, repeats, wrong outputs, stray restarts
      for (int r = 0; r < 40; r++) begin
         int err;
         err = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 6));
         cyc(1'b1, 1'b0, 0, 1'b0);
         for (int c = 0; c < 400 && m_phase != 3; c++) begin
            int  vec;
            bit  o, v, st;
            vec = int'($urandom_range(0, 7));
            o   = maj[vec] ^ (int'($urandom_range(0, 15)) < err);
            v   = ($urandom_range(0, 9) < 7);
            st  = ($urandom_range(0, 299) == 0);
            cyc(st, v, vec, o);
         end
         chk("rand_done", {7'b0, done}, 8'h01);
         repeat ($urandom_range(0, 3))
            cyc(1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
